// File: rtl/shared_mac_array.sv
// Shared-operand MAC array: N_MAC lanes multiply a broadcast or grouped feature by
// per-lane weights and accumulate with saturation over a job of cfg_len beats.
module shared_mac_array #(
  parameter int N_MAC = 16,
  parameter int N_GRP = 4,
  parameter int A_W   = 16,
  parameter int B_W   = 8,
  parameter int ACC_W = 23,
  parameter int LEN_W = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_mode,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic                     start,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_GRP*A_W-1:0]     f_data,
  input  logic [N_MAC*B_W-1:0]     w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_MAC*ACC_W-1:0]   out_data,
  output logic [N_MAC-1:0]         out_ovf
);

  localparam int P_W   = A_W + B_W;
  localparam int SUM_W = ((P_W > ACC_W) ? P_W : ACC_W) + 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  function automatic logic sat_hit(input logic signed [SUM_W-1:0] s);
    return (s > ACC_MAX) || (s < ACC_MIN);
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] s);
    if (s > ACC_MAX)      return ACC_MAX[ACC_W-1:0];
    else if (s < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    else                  return s[ACC_W-1:0];
  endfunction

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;

  state_t           state, state_nxt;
  logic             mode_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             drain_q;
  logic             clr;
  logic             accept;
  logic             vld_p0;

  assign accept = in_ready && in_valid;

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && (cfg_len != '0)) begin
          clr       = 1'b1;
          state_nxt = ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && (cnt + LEN_W'(1) == len_q)) state_nxt = DRAIN;
      end
      DRAIN:   if (drain_q) state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // DRAIN spans two cycles so the last product reaches the accumulators before HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      len_q   <= '0;
      cnt     <= '0;
      drain_q <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      state   <= state_nxt;
      vld_p0  <= accept;
      drain_q <= (state == DRAIN) && !drain_q;
      if (clr) begin
        mode_q <= cfg_mode;
        len_q  <= cfg_len;
        cnt    <= '0;
      end else if (accept) begin
        cnt <= cnt + LEN_W'(1);
      end
    end
  end

  for (genvar i = 0; i < N_MAC; i++) begin : g_lane
    localparam int G = i % N_GRP;
    logic signed [A_W-1:0]   a;
    logic signed [B_W-1:0]   b;
    logic signed [P_W-1:0]   prod_p0;
    logic signed [SUM_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_p1;
    logic                    ovf_p1;

    assign a   = mode_q ? f_data[G*A_W +: A_W] : f_data[A_W-1:0];
    assign b   = w_data[i*B_W +: B_W];
    assign sum = SUM_W'(acc_p1) + SUM_W'(prod_p0);

    // Stage 0: product register
    always_ff @(posedge clk) begin
      if (accept) prod_p0 <= a * b;
    end

    // Stage 1: saturating accumulate, sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_p1 <= '0;
        ovf_p1 <= 1'b0;
      end else if (clr) begin
        acc_p1 <= '0;
        ovf_p1 <= 1'b0;
      end else if (vld_p0) begin
        acc_p1 <= sat_acc(sum);
        if (sat_hit(sum)) ovf_p1 <= 1'b1;
      end
    end

    assign out_data[i*ACC_W +: ACC_W] = acc_p1;
    assign out_ovf[i]                 = ovf_p1;
  end

endmodule
